// File: rtl/row_to_value_packer.sv
// ---------------------------------------------------------------------------
// row_to_value_packer
//
// Packs a stream of fixed-size rows (COL_COUNT*COL_WIDTH bits per beat) back
// into MEMORY_WIDTH-bit memory words. Each value starts with a little-endian
// length field of VALUE_SIZE_BYTES_NO bytes, followed by the rows
// concatenated byte-contiguously. Only the final word of a value is
// zero-padded.
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset
//   row_data         input row, byte 0 at bits [7:0]
//   row_valid        input row beat valid
//   row_last         final row of the current value
//   row_ready        row beat accepted when row_valid && row_ready
//   value_size_data  total value length in bytes (header included),
//                    sampled on the first row beat of each value
//   output_data      packed memory word, byte 0 at bits [7:0]
//   output_valid     output word valid
//   output_last      final word of the value
//   output_ready     downstream accept
//   size_error       sticky flag: counted length differed from the size field
// ---------------------------------------------------------------------------
module row_to_value_packer #(
    parameter int MEMORY_WIDTH        = 512,
    parameter int COL_COUNT           = 3,
    parameter int COL_WIDTH           = 64,
    parameter int VALUE_SIZE_BYTES_NO = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [COL_COUNT*COL_WIDTH-1:0]     row_data,
    input  logic                               row_valid,
    input  logic                               row_last,
    output logic                               row_ready,
    input  logic [8*VALUE_SIZE_BYTES_NO-1:0]   value_size_data,
    output logic [MEMORY_WIDTH-1:0]            output_data,
    output logic                               output_valid,
    output logic                               output_last,
    input  logic                               output_ready,
    output logic                               size_error
);

    localparam int MEM_BYTES = MEMORY_WIDTH / 8;
    localparam int ROW_W     = COL_COUNT * COL_WIDTH;
    localparam int ROW_BYTES = ROW_W / 8;
    localparam int SIZE_W    = 8 * VALUE_SIZE_BYTES_NO;
    localparam int MERGED_W  = MEMORY_WIDTH + ROW_W;
    localparam int FILL_W    = $clog2(MEM_BYTES) + 1;
    localparam int SHIFT_W   = FILL_W + 3;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t                    state_q, state_d;
    logic [MEMORY_WIDTH-1:0]   acc_q, acc_d;
    logic [FILL_W-1:0]         fill_q, fill_d;
    logic [15:0]               row_count_q, row_count_d;
    logic [SIZE_W-1:0]         size_latched_q, size_latched_d;
    logic [MEMORY_WIDTH-1:0]   out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic                      size_error_q, size_error_d;

    // ---------------------------------------------------------------------
    // Datapath helpers
    // ---------------------------------------------------------------------
    logic                      out_free;
    logic                      row_fire;
    logic [FILL_W-1:0]         fill_eff;
    logic [FILL_W-1:0]         nf;
    logic [FILL_W-1:0]         residual;
    logic [SHIFT_W-1:0]        shamt;
    logic [MEMORY_WIDTH-1:0]   base;
    logic [MEMORY_WIDTH-1:0]   hdr_word;
    logic [MERGED_W-1:0]       merged;
    logic [15:0]               count_next;
    logic [SIZE_W-1:0]         size_eff;
    logic [31:0]               counted_len;

    // Single-entry output register: a new word may be loaded when it is empty
    // or being drained in this same cycle.
    assign out_free  = !out_valid_q || output_ready;
    assign row_ready = out_free && (state_q != FLUSH);
    assign row_fire  = row_valid && row_ready;

    assign output_data  = out_data_q;
    assign output_valid = out_valid_q;
    assign output_last  = out_last_q;
    assign size_error   = size_error_q;

    always_comb begin
        hdr_word               = '0;
        hdr_word[SIZE_W-1:0]   = value_size_data;

        // The first row of a value lands right after the length field.
        if (state_q == HDR) begin
            fill_eff   = FILL_W'(VALUE_SIZE_BYTES_NO);
            base       = hdr_word;
            size_eff   = value_size_data;
            count_next = 16'd1;
        end else begin
            fill_eff   = fill_q;
            base       = acc_q;
            size_eff   = size_latched_q;
            count_next = row_count_q + 16'd1;
        end

        shamt       = {fill_eff, 3'b000};
        merged      = MERGED_W'(base) | (MERGED_W'(row_data) << shamt);
        nf          = fill_eff + FILL_W'(ROW_BYTES);
        residual    = nf - FILL_W'(MEM_BYTES);
        counted_len = 32'(count_next) * 32'(ROW_BYTES) + 32'(VALUE_SIZE_BYTES_NO);
    end

    // ---------------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        fill_d         = fill_q;
        row_count_d    = row_count_q;
        size_latched_d = size_latched_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q && !output_ready;
        out_last_d     = out_last_q;
        size_error_d   = size_error_q;

        if (state_q == FLUSH) begin
            // Residual bytes of the value's final row spill into one more word.
            if (out_free) begin
                out_data_d  = acc_q;
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
                acc_d       = '0;
                fill_d      = '0;
                state_d     = HDR;
            end
        end else if (row_fire) begin
            size_latched_d = size_eff;
            row_count_d    = count_next;

            if (row_last) begin
                row_count_d = '0;
                if (counted_len != 32'(size_eff)) begin
                    size_error_d = 1'b1;
                end
            end

            if (nf < FILL_W'(MEM_BYTES)) begin
                if (row_last) begin
                    out_data_d  = merged[MEMORY_WIDTH-1:0];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    acc_d       = '0;
                    fill_d      = '0;
                    state_d     = HDR;
                end else begin
                    acc_d   = merged[MEMORY_WIDTH-1:0];
                    fill_d  = nf;
                    state_d = FILL;
                end
            end else begin
                out_data_d  = merged[MEMORY_WIDTH-1:0];
                out_valid_d = 1'b1;
                acc_d       = MEMORY_WIDTH'(merged[MERGED_W-1:MEMORY_WIDTH]);
                fill_d      = residual;
                if (row_last && (residual != '0)) begin
                    out_last_d = 1'b0;
                    state_d    = FLUSH;
                end else if (row_last) begin
                    out_last_d = 1'b1;
                    acc_d      = '0;
                    fill_d     = '0;
                    state_d    = HDR;
                end else begin
                    out_last_d = 1'b0;
                    state_d    = FILL;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= HDR;
            acc_q          <= '0;
            fill_q         <= '0;
            row_count_q    <= '0;
            size_latched_q <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            size_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            fill_q         <= fill_d;
            row_count_q    <= row_count_d;
            size_latched_q <= size_latched_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            size_error_q   <= size_error_d;
        end
    end

endmodule

// File: tb/tb_row_to_value_packer.sv
// ---------------------------------------------------------------------------
// tb_row_to_value_packer
//
// Directed bench for row_to_value_packer. Each value's expected memory words
// are built from a flat byte image (length field + row bytes, cut into
// 64-byte words) and queued when the value is driven; words are popped and
// compared as the DUT hands them off.
// ---------------------------------------------------------------------------
module tb_row_to_value_packer;

    localparam int MW  = 512;
    localparam int RW  = 192;
    localparam int RB  = 24;
    localparam int MB  = 64;

    typedef struct {
        logic [MW-1:0] data;
        logic          last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [RW-1:0]  row_data;
    logic           row_valid;
    logic           row_last;
    logic           row_ready;
    logic [15:0]    value_size_data;
    logic [MW-1:0]  output_data;
    logic           output_valid;
    logic           output_last;
    logic           output_ready;
    logic           size_error;

    exp_t           exp_q[$];
    int             checks = 0;
    int             failures = 0;
    int             row_ready_low = 0;
    int             words_seen = 0;
    bit             accepted;
    bit             hold_pending = 1'b0;
    logic [MW-1:0]  held_data;
    logic           held_last;

    row_to_value_packer dut (
        .clk             (clk),
        .rst             (rst),
        .row_data        (row_data),
        .row_valid       (row_valid),
        .row_last        (row_last),
        .row_ready       (row_ready),
        .value_size_data (value_size_data),
        .output_data     (output_data),
        .output_valid    (output_valid),
        .output_last     (output_last),
        .output_ready    (output_ready),
        .size_error      (size_error)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check512(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge (what the next rising edge will
    // transfer), then return 1 time unit after the rising edge for driving.
    task automatic step();
        exp_t e;
        @(negedge clk);
        accepted = row_valid && row_ready && !rst;
        if (!row_ready) row_ready_low++;
        if (hold_pending) begin
            check32("hold_valid", 32'(output_valid), 32'd1);
            check512("hold_data", output_data, held_data);
            check32("hold_last", 32'(output_last), 32'(held_last));
        end
        hold_pending = output_valid && !output_ready && !rst;
        held_data    = output_data;
        held_last    = output_last;
        if (output_valid && output_ready && !rst) begin
            words_seen++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_word observed=%0h expected=none", output_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check512("word_data", output_data, e.data);
                check32("word_last", 32'(output_last), 32'(e.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drive one value. Rows 0..nsend-1 are sent; expected words are queued
    // only when push is set. If stall_row >= 0, output_ready is held low for
    // five cycles while that row is presented.
    task automatic send_value(input int nrows, input int size, input bit aa,
                              input int stall_row, input int nsend, input bit push);
        logic [7:0]    b[$];
        logic [RW-1:0] rows[$];
        logic [RW-1:0] r;
        logic [7:0]    byt;
        logic [15:0]   sz;
        exp_t          e;
        int            nw;
        int            waited;
        sz = 16'(size);
        b.push_back(sz[7:0]);
        b.push_back(sz[15:8]);
        for (int i = 0; i < nrows; i++) begin
            r = '0;
            for (int k = 0; k < RB; k++) begin
                byt = aa ? 8'hAA : 8'($urandom_range(1, 255));
                r[8*k +: 8] = byt;
                b.push_back(byt);
            end
            rows.push_back(r);
        end
        if (push) begin
            nw = (b.size() + MB - 1) / MB;
            for (int w = 0; w < nw; w++) begin
                e.data = '0;
                for (int k = 0; k < MB; k++) begin
                    if (w * MB + k < b.size()) e.data[8*k +: 8] = b[w * MB + k];
                end
                e.last = (w == nw - 1);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < nsend; i++) begin
            row_data        = rows[i];
            row_valid       = 1'b1;
            row_last        = (i == nrows - 1);
            value_size_data = sz;
            if (i == stall_row) output_ready = 1'b0;
            waited   = 0;
            accepted = 1'b0;
            while (!accepted && waited < 200) begin
                step();
                waited++;
                if (i == stall_row && waited == 5) output_ready = 1'b1;
            end
            check32("row_accepted", 32'(accepted), 32'd1);
            if (i == stall_row) check32("stall_accept_cycle", 32'(waited), 32'd6);
        end
        row_valid = 1'b0;
        row_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        step();
        check32("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check32("drain_no_valid", 32'(output_valid), 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        row_data        = '0;
        row_valid       = 1'b0;
        row_last        = 1'b0;
        value_size_data = '0;
        output_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_output_valid", 32'(output_valid), 32'd0);
        check32("rst_output_last", 32'(output_last), 32'd0);
        check512("rst_output_data", output_data, '0);
        check32("rst_size_error", 32'(size_error), 32'd0);
        check32("rst_row_ready", 32'(row_ready), 32'd1);
        rst = 1'b0;

        // 1 row of 0xAA, size 26 -> one word, last
        send_value(1, 26, 1'b1, -1, 1, 1'b1);
        drain();
        check32("t1_words", 32'(words_seen), 32'd1);
        check32("t1_size_error", 32'(size_error), 32'd0);

        // 5 rows, size 122 -> 2 words, no flush cycle
        row_ready_low = 0;
        words_seen    = 0;
        send_value(5, 122, 1'b0, -1, 5, 1'b1);
        drain();
        check32("t2_words", 32'(words_seen), 32'd2);
        check32("t2_no_flush", 32'(row_ready_low), 32'd0);

        // 3 rows, size 74 -> word0 then flush word with 10 bytes
        row_ready_low = 0;
        words_seen    = 0;
        send_value(3, 74, 1'b0, -1, 3, 1'b1);
        drain();
        check32("t3_words", 32'(words_seen), 32'd2);
        check32("t3_flush_row_ready_low", 32'(row_ready_low), 32'd1);

        // 6 rows with a 5-cycle downstream stall after the first word
        words_seen = 0;
        send_value(6, 146, 1'b0, 3, 6, 1'b1);
        drain();
        check32("t4_words", 32'(words_seen), 32'd3);
        check32("t4_size_error", 32'(size_error), 32'd0);

        // length mismatch: 2 rows declared as 100 bytes
        send_value(2, 100, 1'b0, -1, 2, 1'b1);
        drain();
        check32("t5_size_error_set", 32'(size_error), 32'd1);
        send_value(3, 74, 1'b0, -1, 3, 1'b1);
        drain();
        check32("t5_size_error_sticky", 32'(size_error), 32'd1);

        // reset in the middle of a 5-row value
        send_value(5, 122, 1'b0, -1, 2, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check32("t6_rst_valid", 32'(output_valid), 32'd0);
        check32("t6_rst_last", 32'(output_last), 32'd0);
        check512("t6_rst_data", output_data, '0);
        check32("t6_rst_size_error", 32'(size_error), 32'd0);
        check32("t6_rst_row_ready", 32'(row_ready), 32'd1);
        words_seen = 0;
        send_value(1, 26, 1'b1, -1, 1, 1'b1);
        drain();
        check32("t6_words", 32'(words_seen), 32'd1);
        check32("t6_size_error", 32'(size_error), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
